// File: rtl/mem_stage.sv
// Memory pipeline stage: forwards ALU results, issues aligned loads/stores
// to data memory with a bounded wait, and flags misaligned/illegal ops.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        load_en,
  input  logic        store_en,
  input  logic        write_reg,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       pend_rd;
  logic             pend_wen;

  logic accept, is_mem, fault, start, ack_hit, tmo_hit;

  assign in_ready = (state == IDLE);
  assign stall    = (state == ACCESS);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-edge event decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    is_mem    = load_en | store_en;
    fault     = (load_en & store_en) | (is_mem & (addr[1:0] != 2'b00));
    start     = 1'b0;
    ack_hit   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        accept = in_valid;
        start  = in_valid & is_mem & ~fault;
        if (start) state_nxt = ACCESS;
      end
      ACCESS: begin
        // ack only counts while a request is actually on the bus; ack beats timeout
        ack_hit = mem_req & mem_ack;
        tmo_hit = mem_req & ~mem_ack & (cnt == CNT_LAST);
        if (ack_hit || tmo_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered memory request, writeback and fault outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      wb_valid  <= 1'b0;
      wb_en     <= 1'b0;
      wb_rd     <= 5'h0;
      wb_data   <= 32'h0;
      err       <= 1'b0;
      cnt       <= '0;
      pend_rd   <= 5'h0;
      pend_wen  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_en    <= 1'b0;
      err      <= 1'b0;
      if (accept) begin
        if (!is_mem) begin
          wb_valid <= 1'b1;
          wb_en    <= write_reg;
          wb_rd    <= rd;
          wb_data  <= addr;
        end else if (fault) begin
          wb_valid <= 1'b1;
          err      <= 1'b1;
          wb_rd    <= rd;
        end else begin
          mem_req   <= 1'b1;
          mem_we    <= store_en;
          mem_addr  <= addr;
          mem_wdata <= store_en ? wdata : 32'h0;
          cnt       <= '0;
          pend_rd   <= rd;
          pend_wen  <= write_reg & load_en;
        end
      end else if (ack_hit) begin
        mem_req  <= 1'b0;
        wb_valid <= 1'b1;
        wb_en    <= pend_wen;
        wb_rd    <= pend_rd;
        if (!mem_we) wb_data <= mem_rdata;
      end else if (tmo_hit) begin
        mem_req  <= 1'b0;
        wb_valid <= 1'b1;
        err      <= 1'b1;
      end else if (stall && mem_req) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a writeback scoreboard.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, load_en, store_en, write_reg;
  logic [31:0] addr, wdata, mem_addr, mem_wdata, mem_rdata, wb_data;
  logic [4:0]  rd, wb_rd;
  logic        mem_req, mem_we, mem_ack, wb_valid, wb_en, stall, err;

  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } wb_exp_t;

  wb_exp_t q[$];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .load_en(load_en), .store_en(store_en), .write_reg(write_reg),
    .addr(addr), .wdata(wdata), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge and score any writeback
  task automatic cycle();
    wb_exp_t e;
    @(posedge clk);
    #1;
    if (wb_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid), 32'h0);
      end else begin
        e = q.pop_front();
        chk("wb_en", 32'(wb_en), 32'(e.en));
        chk("wb_err", 32'(err), 32'(e.err));
        if (e.en) begin
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_data", wb_data, e.data);
        end
      end
    end else begin
      chk("quiet_en_err", 32'({wb_en, err}), 32'h0);
    end
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    in_valid = v; load_en = ld; store_en = st; write_reg = wr;
    addr = a; wdata = d; rd = r;
  endtask

  task automatic push(input logic en, input logic [4:0] r, input logic [31:0] d, input logic e);
    wb_exp_t x;
    x.en = en; x.rd = r; x.data = d; x.err = e;
    q.push_back(x);
  endtask

  initial begin
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    rst_n = 1'b1;
    cycle();

    // ADD result, then three back-to-back ALU results
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 5'd5);
    push(1'b1, 5'd5, 32'h10, 1'b0);
    cycle();
    chk("add_stall", 32'(stall), 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'(i != 1), 32'hA000 + 32'(i), 32'h0, 5'(10 + i));
      push(1'(i != 1), 5'(10 + i), 32'hA000 + 32'(i), 1'b0);
      cycle();
      chk("b2b_ready", 32'(in_ready), 32'h1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    cycle();

    // LW 0x100, ack in the 3rd request cycle
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'hFFFF_FFFF, 5'd7);
    push(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    chk("lw_we", 32'(mem_we), 32'h0);
    chk("lw_addr", mem_addr, 32'h100);
    chk("lw_wdata", mem_wdata, 32'h0);
    chk("lw_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("lw_req", 32'(mem_req), 32'h1);
      chk("lw_stall", 32'(stall), 32'h1);
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      cycle();
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("lw_req_done", 32'(mem_req), 32'h0);
    chk("lw_stall_done", 32'(stall), 32'h0);

    // SW 0x104, ack in first request cycle
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 32'h1234_5678, 5'd3);
    push(1'b0, 5'd3, 32'h0, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    chk("sw_req", 32'(mem_req), 32'h1);
    chk("sw_we", 32'(mem_we), 32'h1);
    chk("sw_wdata", mem_wdata, 32'h1234_5678);
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    chk("sw_wb_latency", 32'(wb_valid), 32'h1);

    // Misaligned LW and illegal load+store: no request, error writeback
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 5'd4);
    push(1'b0, 5'd4, 32'h0, 1'b1);
    cycle();
    chk("mis_req", 32'(mem_req), 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 32'h0, 5'd6);
    push(1'b0, 5'd6, 32'h0, 1'b1);
    cycle();
    chk("ill_req", 32'(mem_req), 32'h0);
    chk("ill_ready", 32'(in_ready), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    cycle();

    // Timeout: no ack, request held 4 cycles
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 5'd8);
    push(1'b0, 5'd8, 32'h0, 1'b1);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      chk("tmo_req", 32'(mem_req), 32'h1);
      cycle();
    end
    chk("tmo_req_drop", 32'(mem_req), 32'h0);
    chk("tmo_err", 32'(err), 32'h1);

    // Ack on the 4th request cycle beats the timeout
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 5'd9);
    push(1'b1, 5'd9, 32'hCAFE_F00D, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      chk("race_req", 32'(mem_req), 32'h1);
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; end
      cycle();
    end
    mem_ack = 1'b0;
    chk("race_err", 32'(err), 32'h0);

    // Reset during the 2nd access cycle: request drops at once, no writeback
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 5'd11);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    cycle();
    chk("rstacc_req_before", 32'(mem_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstacc_req_async", 32'(mem_req), 32'h0);
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("rstacc_ready", 32'(in_ready), 32'h1);
    chk("rstacc_stall", 32'(stall), 32'h0);
    chk("sb_empty", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
